// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader and its memory.
package lib_loader;

    // Loader FSM states.
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, ERROR} LD_STATE;

    // Frame start byte.
    localparam logic [7:0] HDR_BYTE = 8'hA5;

    // Instruction slots, fixed by the 4-bit CPU instruction pointer.
    localparam int N_INSN = 16;

    // Running checksum step: 8-bit sum that wraps modulo 256.
    function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

endpackage

// File: rtl/prog_loader_mem.sv
// 16x8 program memory: one synchronous write port for the loader and one
// combinational read port for the CPU fetch path. Cleared by reset so no
// stale image survives a reset.
module prog_mem
    import lib_loader::*;
#(
    parameter int DEPTH = N_INSN,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];

    // Next memory contents: the addressed slot takes the write data.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Register array, asynchronously cleared to all zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader. Receives HDR, 16 instruction bytes and a
// checksum over a valid/ready byte port, writes the image into program
// memory in place and releases the CPU only once the checksum matches.
//
// Handshake: a byte transfers on a rising edge where rx_valid && rx_ready;
// the source holds rx_data stable while rx_valid is high and the byte has
// not yet transferred. rx_ready drops only for the single CHECK cycle.
module prog_loader
    import lib_loader::*;
#(
    parameter logic [7:0] HDR   = HDR_BYTE,
    parameter int         DEPTH = N_INSN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic [3:0] rom_addr,
    output logic [7:0] rom_data,
    output logic       cpu_rst_n,
    output logic       loaded,
    output logic       err,
    output LD_STATE    dbg_state
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [4:0] CNT_FULL = 5'(DEPTH);

    LD_STATE    state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] chk_q, chk_d;
    logic       rx_ready_q, rx_ready_d;
    logic       cpu_rst_n_q, cpu_rst_n_d;
    logic       loaded_q, loaded_d;
    logic       err_q, err_d;

    logic          accept;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;

    assign accept = rx_valid && rx_ready_q;

    // Next-state logic; outputs are derived from the next state so they
    // change on the same edge as the state (cpu_rst_n falls on the HDR edge).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        chk_d     = chk_q;
        mem_we    = 1'b0;
        mem_waddr = cnt_q[AW-1:0];
        case (state_q)
            IDLE, RUN, ERROR: begin
                // Anything but a header is consumed and dropped here.
                if (accept && rx_data == HDR) begin
                    state_d = LOAD;
                    cnt_d   = 5'd0;
                    sum_d   = 8'h00;
                end
            end
            LOAD: begin
                // Header bytes are ordinary data here, never a resync.
                if (accept) begin
                    if (cnt_q < CNT_FULL) begin
                        mem_we = 1'b1;
                        sum_d  = chk_add(sum_q, rx_data);
                        cnt_d  = cnt_q + 5'd1;
                    end else begin
                        chk_d   = rx_data;
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                state_d = (sum_q == chk_q) ? RUN : ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rx_ready_d  = (state_d != CHECK);
        cpu_rst_n_d = (state_d == RUN);
        loaded_d    = (state_d == RUN);
        err_d       = (state_d == ERROR);
    end

    // FSM, counter, checksum and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            sum_q       <= 8'h00;
            chk_q       <= 8'h00;
            rx_ready_q  <= 1'b1;
            cpu_rst_n_q <= 1'b0;
            loaded_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            chk_q       <= chk_d;
            rx_ready_q  <= rx_ready_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            loaded_q    <= loaded_d;
            err_q       <= err_d;
        end
    end

    prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (rx_data),
        .raddr (rom_addr),
        .rdata (rom_data)
    );

    assign rx_ready  = rx_ready_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign loaded    = loaded_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames from the test plan
// plus randomized frames with gaps, checked against a frame-level model.
module tb_prog_loader;
    import lib_loader::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic       cpu_rst_n;
    logic       loaded;
    logic       err;
    LD_STATE    dbg_state;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    prog_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .cpu_rst_n (cpu_rst_n),
        .loaded    (loaded),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rst_n    = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
    endtask

    // ---------------- driver tasks ----------------
    // Presents one byte; returns how many edges it waited before transfer.
    task automatic send_byte(input logic [7:0] b, output int waits);
        logic acc;
        rx_data  = b;
        rx_valid = 1'b1;
        waits    = 0;
        acc      = 1'b0;
        while (!acc) begin
            acc = rx_ready;
            @(posedge clk);
            #1;
            if (!acc) begin
                waits++;
                if (waits > 20) begin
                    checks++;
                    errors++;
                    $display("FAIL send_byte_timeout byte=%h waited=%0d required<=20", b, waits);
                    acc = 1'b1;
                end
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d[16], input logic [7:0] chk,
                              input int gap_max, input bit with_hdr, output int waits);
        int w;
        waits = 0;
        if (with_hdr) begin
            idle($urandom_range(0, gap_max));
            send_byte(HDR_BYTE, w);
            waits += w;
        end
        for (int i = 0; i < 16; i++) begin
            idle($urandom_range(0, gap_max));
            send_byte(d[i], w);
            waits += w;
        end
        idle($urandom_range(0, gap_max));
        send_byte(chk, w);
        waits += w;
    endtask

    task automatic read_rom(output logic [7:0] obs[16]);
        for (int i = 0; i < 16; i++) begin
            rom_addr = 4'(i);
            #1;
            obs[i] = rom_data;
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] frame_sum(input logic [7:0] d[16]);
        int s = 0;
        for (int i = 0; i < 16; i++) s += int'(d[i]);
        return 8'(s % 256);
    endfunction

    function automatic logic [7:0] rand_non_hdr();
        logic [7:0] b = 8'($urandom_range(0, 255));
        if (b == HDR_BYTE) b = 8'h5A;
        return b;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] obs[16];
        rom_addr = 4'd0;
        do_reset();
        read_rom(obs);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs[i] !== 8'h00) begin
                errors++;
                $display("FAIL reset_mem[%0d] got=%h exp=00", i, obs[i]);
            end
        end
        checks++;
        if ({cpu_rst_n, rx_ready, loaded, err} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_flags cpu_rst_n/rx_ready/loaded/err got=%b exp=0100",
                     {cpu_rst_n, rx_ready, loaded, err});
        end
        checks++;
        if (dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE);
        end
    endtask

    task automatic test_good_frame();
        logic [7:0] d[16];
        logic [7:0] obs[16];
        int w;
        int wsum = 0;
        for (int i = 0; i < 16; i++) d[i] = 8'(i + 1);
        rom_addr = 4'd0;
        send_byte(HDR_BYTE, w);
        wsum += w;
        checks++;
        if (cpu_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL good_after_hdr cpu_rst_n got=%b exp=0", cpu_rst_n);
        end
        for (int i = 0; i < 16; i++) begin
            send_byte(d[i], w);
            wsum += w;
            if (i == 0) begin
                checks++;
                if (rom_data !== 8'h01) begin
                    errors++;
                    $display("FAIL good_readback_during_load got=%h exp=01", rom_data);
                end
            end
        end
        // CHK accepted on the 18th edge counting the HDR edge; CHECK follows.
        send_byte(8'h88, w);
        wsum += w;
        checks++;
        if ({rx_ready, cpu_rst_n, loaded} !== 3'b000) begin
            errors++;
            $display("FAIL good_check_cycle rx_ready/cpu_rst_n/loaded got=%b exp=000",
                     {rx_ready, cpu_rst_n, loaded});
        end
        idle(1);
        // 19th edge counting the HDR edge: RUN.
        checks++;
        if ({rx_ready, cpu_rst_n, loaded, err} !== 4'b1110) begin
            errors++;
            $display("FAIL good_run rx_ready/cpu_rst_n/loaded/err got=%b exp=1110",
                     {rx_ready, cpu_rst_n, loaded, err});
        end
        checks++;
        if (wsum !== 0) begin
            errors++;
            $display("FAIL good_backpressure waits got=%0d exp=0", wsum);
        end
        read_rom(obs);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs[i] !== d[i]) begin
                errors++;
                $display("FAIL good_mem[%0d] got=%h exp=%h", i, obs[i], d[i]);
            end
        end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] d[16];
        logic [7:0] obs[16];
        int w;
        for (int i = 0; i < 16; i++) d[i] = 8'(i + 1);
        send_frame(d, 8'h87, 0, 1'b1, w);
        idle(1);
        checks++;
        if ({err, cpu_rst_n, loaded} !== 3'b100) begin
            errors++;
            $display("FAIL bad_chk err/cpu_rst_n/loaded got=%b exp=100", {err, cpu_rst_n, loaded});
        end
        for (int i = 0; i < 16; i++) d[i] = 8'($urandom_range(0, 255));
        send_frame(d, frame_sum(d), 0, 1'b1, w);
        idle(1);
        checks++;
        if ({err, cpu_rst_n, loaded} !== 3'b011) begin
            errors++;
            $display("FAIL bad_then_good err/cpu_rst_n/loaded got=%b exp=011", {err, cpu_rst_n, loaded});
        end
        read_rom(obs);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs[i] !== d[i]) begin
                errors++;
                $display("FAIL bad_then_good_mem[%0d] got=%h exp=%h", i, obs[i], d[i]);
            end
        end
    endtask

    task automatic test_embedded_hdr();
        logic [7:0] d[16];
        logic [7:0] obs[16];
        int w;
        do_reset();
        send_byte(8'h3C, w);
        send_byte(8'h00, w);
        rom_addr = 4'd0;
        #1;
        checks++;
        if ({dbg_state == IDLE, rom_data, loaded} !== {1'b1, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL garbage_dropped idle/mem0/loaded got=%b/%h/%b exp=1/00/0",
                     dbg_state == IDLE, rom_data, loaded);
        end
        for (int i = 0; i < 16; i++) d[i] = rand_non_hdr();
        d[5] = HDR_BYTE;
        send_frame(d, frame_sum(d), 0, 1'b1, w);
        idle(1);
        checks++;
        if ({cpu_rst_n, loaded, err} !== 3'b110) begin
            errors++;
            $display("FAIL embedded_run cpu_rst_n/loaded/err got=%b exp=110", {cpu_rst_n, loaded, err});
        end
        read_rom(obs);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs[i] !== d[i]) begin
                errors++;
                $display("FAIL embedded_mem[%0d] got=%h exp=%h", i, obs[i], d[i]);
            end
        end
    endtask

    task automatic test_reload_reset();
        logic [7:0] d[16];
        logic [7:0] obs[16];
        int w;
        int wsum = 0;
        do_reset();
        for (int i = 0; i < 16; i++) d[i] = 8'($urandom_range(0, 255));
        send_frame(d, frame_sum(d), 0, 1'b1, w);
        idle(1);
        checks++;
        if (cpu_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL reload_pre_run cpu_rst_n got=%b exp=1", cpu_rst_n);
        end
        send_byte(HDR_BYTE, w);
        checks++;
        if ({cpu_rst_n, loaded} !== 2'b00) begin
            errors++;
            $display("FAIL reload_hdr_edge cpu_rst_n/loaded got=%b exp=00", {cpu_rst_n, loaded});
        end
        for (int i = 0; i < 7; i++) begin
            d[i] = 8'($urandom_range(0, 255));
            send_byte(d[i], w);
        end
        rom_addr = 4'd3;
        #1;
        checks++;
        if (rom_data !== d[3]) begin
            errors++;
            $display("FAIL reload_in_place mem[3] got=%h exp=%h", rom_data, d[3]);
        end
        // Asynchronous reset in the middle of the frame.
        rst_n = 1'b0;
        #1;
        read_rom(obs);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs[i] !== 8'h00) begin
                errors++;
                $display("FAIL midreset_mem[%0d] got=%h exp=00", i, obs[i]);
            end
        end
        checks++;
        if ({dbg_state == IDLE, cpu_rst_n, rx_ready} !== 3'b101) begin
            errors++;
            $display("FAIL midreset_flags idle/cpu_rst_n/rx_ready got=%b exp=101",
                     {dbg_state == IDLE, cpu_rst_n, rx_ready});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        // The rest of the abandoned frame must not be taken as an image.
        for (int i = 0; i < 10; i++) begin
            send_byte(rand_non_hdr(), w);
            wsum += w;
        end
        idle(2);
        read_rom(obs);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs[i] !== 8'h00) begin
                errors++;
                $display("FAIL post_reset_mem[%0d] got=%h exp=00", i, obs[i]);
            end
        end
        checks++;
        if ({loaded, err, cpu_rst_n, wsum != 0} !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_idle loaded/err/cpu_rst_n/stalled got=%b exp=0000",
                     {loaded, err, cpu_rst_n, wsum != 0});
        end
    endtask

    task automatic test_random_gaps();
        logic [7:0] d[16];
        logic [7:0] obs[16];
        logic [7:0] chk;
        logic [7:0] exp_b;
        bit         good;
        bit         with_hdr = 1'b1;
        int         tail;
        int         w;
        do_reset();
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < 16; i++) d[i] = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            chk  = good ? frame_sum(d) : frame_sum(d) + 8'($urandom_range(1, 255));
            send_frame(d, chk, $urandom_range(0, 3), with_hdr, w);
            with_hdr = 1'b1;
            checks++;
            if (w !== 0) begin
                errors++;
                $display("FAIL rand%0d_load_stall waits got=%0d exp=0", f, w);
            end
            tail = $urandom_range(0, 2);
            if (tail == 0) begin
                // Byte offered during CHECK: held one cycle, then dropped.
                send_byte(rand_non_hdr(), w);
            end else if (tail == 1) begin
                idle(1);
                w = 1;
            end else begin
                // Header offered during CHECK: held, then starts a reload.
                send_byte(HDR_BYTE, w);
                with_hdr = 1'b0;
            end
            checks++;
            if (w !== 1) begin
                errors++;
                $display("FAIL rand%0d_check_holdoff waits got=%0d exp=1", f, w);
            end
            checks++;
            if (tail == 2) begin
                if ({cpu_rst_n, loaded, err} !== 3'b000) begin
                    errors++;
                    $display("FAIL rand%0d_reload cpu_rst_n/loaded/err got=%b exp=000",
                             f, {cpu_rst_n, loaded, err});
                end
            end else if ({cpu_rst_n, loaded, err} !== {good, good, !good}) begin
                errors++;
                $display("FAIL rand%0d_outcome cpu_rst_n/loaded/err got=%b exp=%b",
                         f, {cpu_rst_n, loaded, err}, {good, good, !good});
            end
            for (int i = 0; i < 16; i++) exp_q.push_back(d[i]);
            read_rom(obs);
            for (int i = 0; i < 16; i++) begin
                exp_b = exp_q.pop_front();
                checks++;
                if (obs[i] !== exp_b) begin
                    errors++;
                    $display("FAIL rand%0d_mem[%0d] got=%h exp=%h", f, i, obs[i], exp_b);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rom_addr = 4'd0;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_embedded_hdr();
        test_reload_reset();
        test_random_gaps();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #5000000;
        $display("FAIL global_timeout sim_time=%0t limit=5000000", $time);
        $fatal(1, "time limit reached");
    end

endmodule
